// File: rtl/ssd_scan_controller.sv
// Time-multiplexed scan controller for the 8-digit Nexys4 seven-segment display.
// Shadowed data is swapped only at frame boundaries; adds ghost blanking and 16-level PWM.
module ssd_scan_controller #(
    parameter int unsigned BLANK_CYCLES = 1024,
    parameter int unsigned ON_CYCLES    = 261120
) (
    input  logic        ClkPort,
    input  logic        Reset_n,
    input  logic [31:0] data_in,
    input  logic [7:0]  dp_in,
    input  logic [7:0]  digit_en_in,
    input  logic [3:0]  bright,
    input  logic        load_req,
    output logic        load_ack,
    output logic        frame_start,
    output logic [7:0]  An,
    output logic [7:0]  Cathodes
);

    localparam int unsigned SLOT = BLANK_CYCLES + ON_CYCLES;
    localparam int unsigned CW   = $clog2(SLOT);

    typedef enum logic {StBlank, StOn} state_e;

    state_e         state_q;
    logic [CW-1:0]  cnt_q;
    logic [2:0]     idx_q;
    logic [31:0]    sh_data_q;
    logic [7:0]     sh_dp_q;
    logic [7:0]     sh_en_q;

    logic           last_cnt;
    logic           frame_wrap;
    logic [CW-1:0]  on_rel;
    logic [3:0]     pwm_phase;
    logic           pwm_on;
    logic           lit;
    logic [3:0]     nibble;
    logic [6:0]     seg;

    assign last_cnt   = (cnt_q == CW'(SLOT - 1));
    assign frame_wrap = last_cnt && (idx_q == 3'd7);
    assign on_rel     = cnt_q - CW'(BLANK_CYCLES);
    assign pwm_phase  = on_rel[3:0];
    assign pwm_on     = (bright == 4'hF) || (pwm_phase < bright);
    assign lit        = (state_q == StOn) && sh_en_q[idx_q] && pwm_on;
    assign nibble     = sh_data_q[{idx_q, 2'b00} +: 4];

    // abcdefg, active-low
    always_comb begin
        seg = 7'b1111111;
        unique case (nibble)
            4'h0: seg = 7'b0000001;
            4'h1: seg = 7'b1001111;
            4'h2: seg = 7'b0010010;
            4'h3: seg = 7'b0000110;
            4'h4: seg = 7'b1001100;
            4'h5: seg = 7'b0100100;
            4'h6: seg = 7'b0100000;
            4'h7: seg = 7'b0001111;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0000100;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b1100000;
            4'hC: seg = 7'b0110001;
            4'hD: seg = 7'b1000010;
            4'hE: seg = 7'b0110000;
            4'hF: seg = 7'b0111000;
        endcase
    end

    always_ff @(posedge ClkPort or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q     <= StBlank;
            cnt_q       <= '0;
            idx_q       <= 3'd0;
            sh_data_q   <= 32'h0;
            sh_dp_q     <= 8'h00;
            sh_en_q     <= 8'h00;
            load_ack    <= 1'b0;
            frame_start <= 1'b0;
            An          <= 8'hFF;
            Cathodes    <= 8'hFF;
        end else begin
            if (last_cnt) begin
                cnt_q <= '0;
                idx_q <= idx_q + 3'd1;
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end

            unique case (state_q)
                StBlank: if (cnt_q == CW'(BLANK_CYCLES - 1)) state_q <= StOn;
                StOn:    if (last_cnt) state_q <= StBlank;
            endcase

            frame_start <= frame_wrap;
            load_ack    <= frame_wrap && load_req;
            if (frame_wrap && load_req) begin
                sh_data_q <= data_in;
                sh_dp_q   <= dp_in;
                sh_en_q   <= digit_en_in;
            end

            // Outputs mirror this cycle's slot position, one cycle later.
            if (lit) begin
                An       <= ~(8'h01 << idx_q);
                Cathodes <= {seg, ~sh_dp_q[idx_q]};
            end else begin
                An       <= 8'hFF;
                Cathodes <= 8'hFF;
            end
        end
    end

endmodule

// File: tb/tb_ssd_scan_controller.sv
// Directed bench for ssd_scan_controller with 2 blank + 16 on cycles per slot (144-cycle frame).
module tb_ssd_scan_controller;

    localparam int BLANK = 2;
    localparam int ONC   = 16;
    localparam int S     = BLANK + ONC;
    localparam int FRAME = 8 * S;

    logic        ClkPort = 1'b0;
    logic        Reset_n;
    logic [31:0] data_in;
    logic [7:0]  dp_in;
    logic [7:0]  digit_en_in;
    logic [3:0]  bright;
    logic        load_req;
    logic        load_ack;
    logic        frame_start;
    logic [7:0]  An;
    logic [7:0]  Cathodes;

    int checks = 0;
    int errors = 0;

    // Bench-side copy of what the shadows should hold
    logic [31:0] m_data;
    logic [7:0]  m_dp;
    logic [7:0]  m_en;

    // Per-frame capture, index j = digit*S + slot counter
    logic [7:0] an_cap [FRAME];
    logic [7:0] ca_cap [FRAME];
    int         lit_cnt [8];
    logic [7:0] an_and;

    // Mid-frame request injection
    int          mid_off;
    logic [31:0] mid_data;
    logic [7:0]  mid_dp;
    logic [7:0]  mid_en;

    logic [6:0] seg_tab [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    ssd_scan_controller #(
        .BLANK_CYCLES(BLANK),
        .ON_CYCLES   (ONC)
    ) dut (
        .ClkPort    (ClkPort),
        .Reset_n    (Reset_n),
        .data_in    (data_in),
        .dp_in      (dp_in),
        .digit_en_in(digit_en_in),
        .bright     (bright),
        .load_req   (load_req),
        .load_ack   (load_ack),
        .frame_start(frame_start),
        .An         (An),
        .Cathodes   (Cathodes)
    );

    always #5 ClkPort = ~ClkPort;

    // Starts on a frame_start cycle; steps through the whole frame ending on the next one.
    task automatic run_frame();
        int j, d, c;
        logic lit;
        logic [7:0] ea, ec;
        for (int k = 0; k < 8; k++) lit_cnt[k] = 0;
        an_and = 8'hFF;
        for (int off = 1; off <= FRAME; off++) begin
            @(negedge ClkPort);
            j = off - 1;
            d = j / S;
            c = j % S;
            lit = (c >= BLANK) && m_en[d] && ((bright == 4'hF) || ((c - BLANK) < int'(bright)));
            ea = lit ? ~(8'h01 << d) : 8'hFF;
            ec = lit ? {seg_tab[m_data[d*4 +: 4]], ~m_dp[d]} : 8'hFF;
            an_cap[j] = An;
            ca_cap[j] = Cathodes;
            an_and = an_and & An;
            if (An != 8'hFF) lit_cnt[d]++;
            checks++;
            if (An !== ea || Cathodes !== ec) begin
                errors++;
                $display("FAIL scan off=%0d: An=%h Cathodes=%h, expected An=%h Cathodes=%h",
                         off, An, Cathodes, ea, ec);
            end
            checks++;
            if (frame_start !== (off == FRAME)) begin
                errors++;
                $display("FAIL frame_start off=%0d: got %b expected %b",
                         off, frame_start, off == FRAME);
            end
            if (off < FRAME) begin
                checks++;
                if (load_ack !== 1'b0) begin
                    errors++;
                    $display("FAIL load_ack off=%0d: got %b expected 0", off, load_ack);
                end
            end
            if (off == mid_off) begin
                data_in     = mid_data;
                dp_in       = mid_dp;
                digit_en_in = mid_en;
                load_req    = 1'b1;
            end
        end
        mid_off = -1;
    endtask

    task automatic test_reset();
        Reset_n = 1'b0;
        data_in = 32'h0; dp_in = 8'h00; digit_en_in = 8'h00;
        bright = 4'hF; load_req = 1'b0;
        m_data = 32'h0; m_dp = 8'h00; m_en = 8'h00;
        mid_off = -1;
        repeat (4) @(negedge ClkPort);
        checks++;
        if (An !== 8'hFF || Cathodes !== 8'hFF || load_ack !== 1'b0 || frame_start !== 1'b0) begin
            errors++;
            $display("FAIL reset_values: An=%h Cathodes=%h ack=%b fs=%b, expected FF FF 0 0",
                     An, Cathodes, load_ack, frame_start);
        end
        Reset_n = 1'b1;
        @(negedge ClkPort);
        checks++;
        if (frame_start !== 1'b0) begin
            errors++;
            $display("FAIL fs_after_release: got %b expected 0", frame_start);
        end
        for (int i = 0; i < 3 * FRAME; i++) begin
            @(negedge ClkPort);
            checks++;
            if (An !== 8'hFF || Cathodes !== 8'hFF || load_ack !== 1'b0) begin
                errors++;
                $display("FAIL dark_before_load cyc=%0d: An=%h Cathodes=%h ack=%b, expected FF FF 0",
                         i, An, Cathodes, load_ack);
            end
        end
    endtask

    task automatic test_load();
        bit seen;
        data_in = 32'h89ABCDEF; dp_in = 8'h01; digit_en_in = 8'hFF;
        bright = 4'hF; load_req = 1'b1;
        seen = 0;
        for (int i = 0; i < 2 * FRAME + 4 && !seen; i++) begin
            @(negedge ClkPort);
            if (load_ack === 1'b1) seen = 1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL load_ack_timeout: got none expected pulse");
            $display("Simulation finished: %0d checks, %0d errors", checks, errors);
            $fatal(1);
        end
        checks++;
        if (frame_start !== 1'b1) begin
            errors++;
            $display("FAIL ack_with_fs: frame_start=%b expected 1", frame_start);
        end
        load_req = 1'b0;
        m_data = 32'h89ABCDEF; m_dp = 8'h01; m_en = 8'hFF;
        run_frame();
        checks++;
        if (an_cap[5] !== 8'hFE || ca_cap[5] !== 8'h70) begin
            errors++;
            $display("FAIL digit0_on: An=%h Cathodes=%h expected FE 70", an_cap[5], ca_cap[5]);
        end
        checks++;
        if (an_cap[S + 5] !== 8'hFD || ca_cap[S + 5] !== 8'h61) begin
            errors++;
            $display("FAIL digit1_on: An=%h Cathodes=%h expected FD 61", an_cap[S+5], ca_cap[S+5]);
        end
        checks++;
        if (an_cap[S] !== 8'hFF || ca_cap[S + 1] !== 8'hFF) begin
            errors++;
            $display("FAIL digit1_blank: An=%h Cathodes=%h expected FF FF", an_cap[S], ca_cap[S+1]);
        end
    endtask

    task automatic test_midframe_load();
        mid_off = 40; mid_data = 32'h0; mid_dp = 8'h00; mid_en = 8'hFF;
        run_frame();
        checks++;
        if (load_ack !== 1'b1) begin
            errors++;
            $display("FAIL mid_ack: got %b expected 1", load_ack);
        end
        load_req = 1'b0;
        m_data = 32'h0; m_dp = 8'h00; m_en = 8'hFF;
        run_frame();
        checks++;
        if (an_cap[5] !== 8'hFE || ca_cap[5] !== 8'h03) begin
            errors++;
            $display("FAIL zero_digit0: An=%h Cathodes=%h expected FE 03", an_cap[5], ca_cap[5]);
        end
    endtask

    task automatic test_brightness();
        logic [3:0] lv [3] = '{4'h0, 4'h8, 4'hF};
        int         ex [3] = '{0, 8, 16};
        for (int b = 0; b < 3; b++) begin
            bright = lv[b];
            run_frame();
            for (int d = 0; d < 8; d++) begin
                checks++;
                if (lit_cnt[d] != ex[b]) begin
                    errors++;
                    $display("FAIL bright_%h digit%0d: lit=%0d expected %0d",
                             lv[b], d, lit_cnt[d], ex[b]);
                end
            end
        end
        bright = 4'hF;
    endtask

    task automatic test_digit_enable();
        data_in = 32'h12345678; dp_in = 8'h00; digit_en_in = 8'h0F; load_req = 1'b1;
        run_frame();
        checks++;
        if (load_ack !== 1'b1) begin
            errors++;
            $display("FAIL en_ack: got %b expected 1", load_ack);
        end
        load_req = 1'b0;
        m_data = 32'h12345678; m_dp = 8'h00; m_en = 8'h0F;
        run_frame();
        checks++;
        if (an_and[7:4] !== 4'hF) begin
            errors++;
            $display("FAIL upper_dark: An[7:4] and-over-frame=%h expected F", an_and[7:4]);
        end
        checks++;
        if (lit_cnt[3] != 16) begin
            errors++;
            $display("FAIL digit3_lit: got %0d expected 16", lit_cnt[3]);
        end
    endtask

    task automatic test_reset_mid();
        // digit 3, counter 4: lit with nibble 5, Dp off
        repeat (3 * S + 5) @(negedge ClkPort);
        checks++;
        if (An !== 8'hF7 || Cathodes !== 8'h49) begin
            errors++;
            $display("FAIL pre_reset: An=%h Cathodes=%h expected F7 49", An, Cathodes);
        end
        Reset_n = 1'b0;
        #1;
        checks++;
        if (An !== 8'hFF || Cathodes !== 8'hFF || load_ack !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: An=%h Cathodes=%h ack=%b expected FF FF 0",
                     An, Cathodes, load_ack);
        end
        repeat (3) @(negedge ClkPort);
        Reset_n = 1'b1;
        for (int i = 0; i < 2 * FRAME + 2; i++) begin
            @(negedge ClkPort);
            checks++;
            if (An !== 8'hFF || Cathodes !== 8'hFF) begin
                errors++;
                $display("FAIL dark_after_reset cyc=%0d: An=%h Cathodes=%h expected FF FF",
                         i, An, Cathodes);
            end
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_midframe_load();
        test_brightness();
        test_digit_enable();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
